// File: rtl/rns_pkg.sv
// Shared types and constants for the RNS converter scheduler.
//   INT_W / RNS_W : integer and RNS operand widths
//   rns_op_e      : request operation (int->RNS or RNS->int)
//   state_e       : scheduler FSM states
//   id_w()        : width of a requester index, never less than 1 bit
package rns_pkg;

  localparam int INT_W = 64;
  localparam int RNS_W = 65;

  typedef enum logic {
    OP_TO_RNS = 1'b0,
    OP_TO_INT = 1'b1
  } rns_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches i_req starting one past i_ptr (wrapping modulo N) and grants the
// first set bit. The pointer register lives in the caller.
//   i_req   : request vector
//   i_ptr   : index of the last served requester
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : encoded index of the grant
//   o_any   : at least one request present
module rr_arbiter
  import rns_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Two copies side by side, shifted so bit 0 is the requester right after
  // i_ptr; a plain LSB-first scan then yields the round-robin winner.
  logic [2*N-1:0] w_rot;

  always_comb begin
    w_rot   = {i_req, i_req} >> (int'(i_ptr) + 1);
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + 1 + k) % N);
      end
    end
    if (o_any) o_grant = N'(1) << o_idx;
  end

endmodule

// File: rtl/rns_conv_scheduler.sv
// Time-shares one int->RNS / RNS->int converter pair between NREQ requesters.
// A round-robin grant latches one operand, holds it on the converter inputs for
// CONV_LAT cycles, captures the selected result and presents it on a
// valid/ready response channel together with the requester index.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_req_valid/o_req_ready : per-requester handshake (ready is one-hot or 0)
//   i_req_op, i_req_data    : per-requester op and flattened 65-bit operands
//   o_rsp_*, i_rsp_ready    : response channel (id, op, 65-bit data)
//   o_busy                  : high whenever the FSM is not idle
//   o_c2r_in / i_c2r_out    : int->RNS converter port
//   o_r2c_in / i_r2c_out    : RNS->int converter port
module rns_conv_scheduler
  import rns_pkg::*;
#(
  parameter int  NREQ     = 4,
  parameter int  CONV_LAT = 2,
  localparam int IDW      = id_w(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0]       i_req_op,
  input  logic [NREQ*RNS_W-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_rsp_op,
  output logic [RNS_W-1:0]      o_rsp_data,
  output logic                  o_busy,
  output logic [INT_W-1:0]      o_c2r_in,
  input  logic [RNS_W-1:0]      i_c2r_out,
  output logic [RNS_W-1:0]      o_r2c_in,
  input  logic [INT_W-1:0]      i_r2c_out
);

  // Counter only has to hold CONV_LAT-1.
  localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  state_e           r_state, w_state_d;
  logic [IDW-1:0]   r_ptr, r_id_q, r_rsp_id, w_gidx;
  logic [CNT_W-1:0] r_cnt;
  rns_op_e          r_op_q;
  logic             r_rsp_op;
  logic [RNS_W-1:0] r_data_q, r_rsp_data, w_sel_data, w_result;
  logic [NREQ-1:0]  w_grant, w_req_ready;
  logic             w_any, w_sel_op, w_accept, w_capture;

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    w_sel_op   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_data = i_req_data[i*RNS_W +: RNS_W];
        w_sel_op   = i_req_op[i];
      end
    end
  end

  assign w_result = (r_op_q == OP_TO_INT) ? {1'b0, i_r2c_out} : i_c2r_out;

  always_comb begin
    w_state_d   = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        // A grant always coincides with a valid, so presenting ready is the
        // transfer itself.
        w_req_ready = w_grant;
        if (w_any) begin
          w_accept  = 1'b1;
          w_state_d = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ptr      <= IDW'(NREQ - 1);
      r_cnt      <= '0;
      r_data_q   <= '0;
      r_op_q     <= OP_TO_RNS;
      r_id_q     <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_op   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op_q   <= rns_op_e'(w_sel_op);
        r_data_q <= w_sel_data;
        r_id_q   <= w_gidx;
        r_ptr    <= w_gidx;
        r_cnt    <= CNT_W'(CONV_LAT - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_data <= w_result;
        r_rsp_id   <= r_id_q;
        r_rsp_op   <= r_op_q;
      end
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_op    = r_rsp_op;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = (r_state != IDLE);
  // Converter inputs come straight from the operand register so they stay
  // constant from WAIT entry until the response is taken.
  assign o_c2r_in    = r_data_q[INT_W-1:0];
  assign o_r2c_in    = r_data_q;

endmodule
